// File: rtl/gpio_pad_agent_if.sv
// Control and status bundle for gpio_pad_agent: pad drive registers,
// synchronised pad monitor, masked compare-and-wait and edge counter.
// The pad bus itself stays a plain inout port on the agent.
interface gpio_pad_agent_if #(
   parameter int NPADS = 38,
   parameter int TMO_W = 16,
   parameter int CNT_W = 16,
   parameter int SEL_W = (NPADS > 1) ? $clog2(NPADS) : 1
);
   logic             drv_wr;
   logic [NPADS-1:0] drv_val;
   logic [NPADS-1:0] drv_en;
   logic [NPADS-1:0] mon_val;
   logic             wait_start;
   logic [NPADS-1:0] wait_mask;
   logic [NPADS-1:0] wait_value;
   logic [TMO_W-1:0] wait_timeout;
   logic             wait_busy;
   logic             wait_done;
   logic             wait_hit;
   logic [SEL_W-1:0] cnt_sel;
   logic             cnt_clear;
   logic [CNT_W-1:0] edge_cnt;

   modport master (
      output drv_wr, drv_val, drv_en,
      input  mon_val,
      output wait_start, wait_mask, wait_value, wait_timeout,
      input  wait_busy, wait_done, wait_hit,
      output cnt_sel, cnt_clear,
      input  edge_cnt
   );

   modport slave (
      input  drv_wr, drv_val, drv_en,
      output mon_val,
      input  wait_start, wait_mask, wait_value, wait_timeout,
      output wait_busy, wait_done, wait_hit,
      input  cnt_sel, cnt_clear,
      output edge_cnt
   );
endinterface

// File: rtl/gpio_pad_agent.sv
// GPIO pad agent: drives or releases each pad, samples the pads through a
// two-flop synchroniser, waits for a masked pattern with a timeout, and
// counts rising edges on one selectable pad with a saturating counter.
module gpio_pad_agent #(
   parameter int NPADS = 38,
   parameter int TMO_W = 16,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             resetb,
   inout  wire  [NPADS-1:0] pad,
   gpio_pad_agent_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } waitState_t;

   logic [NPADS-1:0] drvVal_q;
   logic [NPADS-1:0] drvEn_q;
   logic [NPADS-1:0] syncA_q;
   logic [NPADS-1:0] syncB_q;
   logic [NPADS-1:0] prev_q;

   logic [NPADS-1:0] mask_q,    mask_d;
   logic [NPADS-1:0] value_q,   value_d;
   logic [TMO_W-1:0] timeout_q, timeout_d;
   logic [TMO_W-1:0] count_q,   count_d;
   logic             hit_q,     hit_d;
   waitState_t       state_q,   state_d;

   logic [CNT_W-1:0] edgeCnt_q, edgeCnt_d;
   logic             curBit;
   logic             prevBit;

   // Drive registers: value and enable are always loaded together
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         drvVal_q <= '0;
         drvEn_q  <= '0;
      end else if (bus.drv_wr) begin
         drvVal_q <= bus.drv_val;
         drvEn_q  <= bus.drv_en;
      end
   end

   for (genvar i = 0; i < NPADS; i++) begin : g_pad
      assign pad[i] = drvEn_q[i] ? drvVal_q[i] : 1'bz;
   end

   // Two-flop synchroniser plus the previous-sample copy used for edge detection
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         syncA_q <= '0;
         syncB_q <= '0;
         prev_q  <= '0;
      end else begin
         syncA_q <= pad;
         syncB_q <= syncA_q;
         prev_q  <= syncB_q;
      end
   end

   assign bus.mon_val = syncB_q;

   // Pick the selected pad's current/previous sample; out-of-range selects read as no edge
   always_comb begin
      curBit  = 1'b0;
      prevBit = 1'b0;
      if (int'(bus.cnt_sel) < NPADS) begin
         curBit  = syncB_q[bus.cnt_sel];
         prevBit = prev_q[bus.cnt_sel];
      end
   end

   // Edge counter next state: clear beats increment, and the count sticks at all-ones
   always_comb begin
      edgeCnt_d = edgeCnt_q;
      if (bus.cnt_clear) begin
         edgeCnt_d = '0;
      end else if (curBit && !prevBit && (edgeCnt_q != '1)) begin
         edgeCnt_d = edgeCnt_q + 1'b1;
      end
   end

   // Edge counter register
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         edgeCnt_q <= '0;
      end else begin
         edgeCnt_q <= edgeCnt_d;
      end
   end

   assign bus.edge_cnt = edgeCnt_q;

   // Wait FSM and its latched compare parameters
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q   <= IDLE;
         mask_q    <= '0;
         value_q   <= '0;
         timeout_q <= '0;
         count_q   <= '0;
         hit_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         value_q   <= value_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
         hit_q     <= hit_d;
      end
   end

   // Wait FSM next state: a match wins over timeout; an x/z on a masked bit never matches
   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      value_d   = value_q;
      timeout_d = timeout_q;
      count_d   = count_q;
      hit_d     = hit_q;
      case (state_q)
         IDLE: begin
            if (bus.wait_start) begin
               state_d   = WAIT;
               mask_d    = bus.wait_mask;
               value_d   = bus.wait_value;
               timeout_d = bus.wait_timeout;
               count_d   = '0;
            end
         end
         WAIT: begin
            if (((syncB_q ^ value_q) & mask_q) == '0) begin
               state_d = DONE;
               hit_d   = 1'b1;
            end else if (count_q == timeout_q) begin
               state_d = DONE;
               hit_d   = 1'b0;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.wait_busy = (state_q != IDLE);
   assign bus.wait_done = (state_q == DONE);
   assign bus.wait_hit  = hit_q;

endmodule

// File: tb/tb_gpio_pad_agent.sv
// Self-checking bench for gpio_pad_agent: drive/release and synchroniser,
// table of masked waits scored through a queue, hand-written corner cases
// for timeout, ignored restarts, edge counting, saturation and async reset.
module tb_gpio_pad_agent;

   localparam int NP  = 38;
   localparam int NP2 = 8;

   logic clock = 1'b0;
   logic resetb;

   wire  [NP-1:0]  pad;
   logic [NP-1:0]  tbEn;
   logic [NP-1:0]  tbVal;
   wire  [NP2-1:0] pad2;
   logic [NP2-1:0] tbEn2;
   logic [NP2-1:0] tbVal2;

   int errors = 0;
   int checks = 0;

   gpio_pad_agent_if #(.NPADS(NP),  .TMO_W(16), .CNT_W(16)) bus  ();
   gpio_pad_agent_if #(.NPADS(NP2), .TMO_W(4),  .CNT_W(2))  bus2 ();

   for (genvar i = 0; i < NP; i++) begin : g_tbPad
      assign pad[i] = tbEn[i] ? tbVal[i] : 1'bz;
   end
   for (genvar i = 0; i < NP2; i++) begin : g_tbPad2
      assign pad2[i] = tbEn2[i] ? tbVal2[i] : 1'bz;
   end

   gpio_pad_agent #(.NPADS(NP), .TMO_W(16), .CNT_W(16)) dut (
      .clock (clock),
      .resetb(resetb),
      .pad   (pad),
      .bus   (bus)
   );

   gpio_pad_agent #(.NPADS(NP2), .TMO_W(4), .CNT_W(2)) dutSat (
      .clock (clock),
      .resetb(resetb),
      .pad   (pad2),
      .bus   (bus2)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic  hit;
      int    cycles;
      string name;
   } waitExp_t;

   waitExp_t expQ[$];

   typedef struct {
      logic [NP-1:0] pads;
      logic [NP-1:0] mask;
      logic [NP-1:0] value;
      logic [15:0]   tmo;
      logic          expHit;
      int            expCycles;
   } vec_t;

   vec_t vecs[7];

   task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic int countHigh(logic [NP-1:0] v);
      int n = 0;
      for (int i = 0; i < NP; i++) begin
         if (v[i] === 1'b1) n++;
      end
      return n;
   endfunction

   // Scoreboard: every wait_done pops one expectation and checks hit and WAIT length
   int   waitCycles = 0;
   logic prevDone   = 1'b0;
   always @(negedge clock) begin
      waitExp_t e;
      if (!resetb) begin
         waitCycles = 0;
         prevDone   = 1'b0;
      end else begin
         if (bus.wait_busy && !bus.wait_done) waitCycles++;
         if (bus.wait_done) begin
            if (prevDone) begin
               checkOutput("done_width", 64'(2), 64'(1));
            end else if (expQ.size() == 0) begin
               checkOutput("unexpected_done", 64'(1), 64'(0));
            end else begin
               e = expQ.pop_front();
               checkOutput({e.name, "_hit"},    64'(bus.wait_hit), 64'(e.hit));
               checkOutput({e.name, "_cycles"}, 64'(waitCycles),   64'(e.cycles));
            end
            waitCycles = 0;
         end
         prevDone = bus.wait_done;
      end
   end

   task automatic settle(int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulseBits(logic [NP-1:0] bits, int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         tbVal = tbVal | bits;
         settle(2);
         tbVal = tbVal & ~bits;
         settle(1);
      end
   endtask

   task automatic pulseSat(int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         tbVal2[0] = 1'b1;
         settle(2);
         tbVal2[0] = 1'b0;
         settle(1);
      end
   endtask

   task automatic drvWrite(logic [NP-1:0] en, logic [NP-1:0] val);
      @(negedge clock);
      bus.drv_wr  = 1'b1;
      bus.drv_en  = en;
      bus.drv_val = val;
      @(negedge clock);
      bus.drv_wr  = 1'b0;
   endtask

   // Start one wait, push its expectation and stay until the scoreboard consumes it;
   // injectAt > 0 fires a second (mask-all-zero) start that many cycles into the wait
   task automatic applyStimulus(string name, logic [NP-1:0] mask, logic [NP-1:0] value,
                                logic [15:0] tmo, logic expHit, int expCycles, int injectAt);
      waitExp_t e;
      int budget;
      @(negedge clock);
      bus.wait_start   = 1'b1;
      bus.wait_mask    = mask;
      bus.wait_value   = value;
      bus.wait_timeout = tmo;
      e.hit    = expHit;
      e.cycles = expCycles;
      e.name   = name;
      expQ.push_back(e);
      @(negedge clock);
      bus.wait_start = 1'b0;
      budget = 0;
      while (expQ.size() != 0 && budget < 200) begin
         @(negedge clock);
         budget++;
         if (budget == injectAt) begin
            bus.wait_start   = 1'b1;
            bus.wait_mask    = '0;
            bus.wait_value   = '0;
            bus.wait_timeout = '0;
         end else begin
            bus.wait_start = 1'b0;
         end
      end
      bus.wait_start = 1'b0;
      if (expQ.size() != 0) begin
         checkOutput({name, "_no_done"}, 64'(expQ.size()), 64'(0));
         expQ.delete();
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{pads: 38'h2A, mask: 38'h0,  value: 38'h3F, tmo: 16'd5, expHit: 1'b1, expCycles: 1};
      vecs[1] = '{pads: 38'h2A, mask: 38'hFF, value: 38'h2A, tmo: 16'd4, expHit: 1'b1, expCycles: 1};
      vecs[2] = '{pads: 38'h2A, mask: 38'hFF, value: 38'h2B, tmo: 16'd3, expHit: 1'b0, expCycles: 4};
      vecs[3] = '{pads: 38'h2A, mask: 38'hFF, value: 38'h00, tmo: 16'd0, expHit: 1'b0, expCycles: 1};
      vecs[4] = '{pads: 38'h2A, mask: 38'hF0, value: 38'h2F, tmo: 16'd2, expHit: 1'b1, expCycles: 1};
      vecs[5] = '{pads: 38'h20_0000_0001, mask: 38'h20_0000_0000, value: 38'h20_0000_0000,
                  tmo: 16'd7, expHit: 1'b1, expCycles: 1};
      vecs[6] = '{pads: 38'h3F_FFFF_FFFF, mask: 38'h3F_FFFF_FFFF, value: 38'h3F_FFFF_FFFE,
                  tmo: 16'd1, expHit: 1'b0, expCycles: 2};

      resetb = 1'b0;
      tbEn   = '0;
      tbVal  = '0;
      tbEn2  = '1;
      tbVal2 = '0;
      bus.drv_wr = 1'b0;  bus.drv_val = '0;  bus.drv_en = '0;
      bus.wait_start = 1'b0;  bus.wait_mask = '0;  bus.wait_value = '0;  bus.wait_timeout = '0;
      bus.cnt_sel = '0;  bus.cnt_clear = 1'b0;
      bus2.drv_wr = 1'b0;  bus2.drv_val = '0;  bus2.drv_en = '0;
      bus2.wait_start = 1'b0;  bus2.wait_mask = '0;  bus2.wait_value = '0;  bus2.wait_timeout = '0;
      bus2.cnt_sel = '0;  bus2.cnt_clear = 1'b0;

      // Reset state
      @(negedge clock);
      checkOutput("rst_mon",   64'(bus.mon_val),   64'(0));
      checkOutput("rst_busy",  64'(bus.wait_busy), 64'(0));
      checkOutput("rst_done",  64'(bus.wait_done), 64'(0));
      checkOutput("rst_hit",   64'(bus.wait_hit),  64'(0));
      checkOutput("rst_cnt",   64'(bus.edge_cnt),  64'(0));
      checkOutput("rst_padHi", 64'(countHigh(pad)), 64'(0));
      @(negedge clock);
      resetb = 1'b1;

      // Drive pad 5 from the agent, watch it appear on mon_val two cycles later
      @(negedge clock);
      bus.drv_wr  = 1'b1;
      bus.drv_en  = 38'h20;
      bus.drv_val = 38'h20;
      @(negedge clock);
      bus.drv_wr = 1'b0;
      checkOutput("drv_pad5",    64'(pad[5]),         64'(1));
      checkOutput("drv_padHi",   64'(countHigh(pad)), 64'(1));
      checkOutput("drv_mon5_t1", 64'(bus.mon_val[5]), 64'(0));
      settle(2);
      checkOutput("drv_mon5_t3", 64'(bus.mon_val[5]), 64'(1));
      tbEn  = ~38'h20;
      tbVal = ~38'h20;
      settle(3);
      checkOutput("drv_mon_all1", 64'(bus.mon_val), 64'(38'h3F_FFFF_FFFF));
      drvWrite('0, '0);
      tbEn  = '1;
      tbVal = '0;
      settle(3);
      checkOutput("release_mon0", 64'(bus.mon_val), 64'(0));

      // Table-driven masked waits with static pad patterns
      for (int i = 0; i < 7; i++) begin
         tbVal = vecs[i].pads;
         settle(3);
         checkOutput($sformatf("vec%0d_mon", i), 64'(bus.mon_val), 64'(vecs[i].pads));
         applyStimulus($sformatf("vec%0d", i), vecs[i].mask, vecs[i].value, vecs[i].tmo,
                       vecs[i].expHit, vecs[i].expCycles, 0);
      end
      settle(3);
      checkOutput("hit_hold0", 64'(bus.wait_hit), 64'(0));

      // Pattern arrives on pads[1:0] four cycles after the start
      tbVal = '0;
      settle(3);
      @(negedge clock);
      bus.wait_start   = 1'b1;
      bus.wait_mask    = 38'h3;
      bus.wait_value   = 38'h2;
      bus.wait_timeout = 16'd10;
      expQ.push_back('{hit: 1'b1, cycles: 6, name: "late_match"});
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         if (k == 1) bus.wait_start = 1'b0;
         if (k == 4) tbVal[1:0] = 2'b10;
      end
      checkOutput("late_busy_after", 64'(bus.wait_busy), 64'(0));
      checkOutput("late_drained",    64'(expQ.size()),   64'(0));
      expQ.delete();
      settle(3);
      checkOutput("hit_hold1", 64'(bus.wait_hit), 64'(1));

      // Never-matching wait with timeout 3 and a restart attempt mid-wait
      tbVal = '0;
      settle(3);
      applyStimulus("tmo3", 38'hFF, 38'h55, 16'd3, 1'b0, 4, 1);
      settle(4);

      // Floating masked pad can never satisfy an expected 1; empty mask always hits
      tbEn[37] = 1'b0;
      settle(3);
      applyStimulus("float", 38'h20_0000_0000, 38'h20_0000_0000, 16'd2, 1'b0, 3, 0);
      applyStimulus("float_mask0", 38'h0, 38'h20_0000_0000, 16'd2, 1'b1, 1, 0);
      tbEn[37] = 1'b1;

      // Edge counter on pad 3
      tbVal = '0;
      bus.cnt_sel = 6'd3;
      settle(3);
      @(negedge clock);
      bus.cnt_clear = 1'b1;
      @(negedge clock);
      bus.cnt_clear = 1'b0;
      checkOutput("cnt_cleared", 64'(bus.edge_cnt), 64'(0));
      pulseBits(38'h8, 5);
      settle(3);
      checkOutput("cnt_5", 64'(bus.edge_cnt), 64'(5));

      // Clear lands on the same cycle as a counted edge
      @(negedge clock);
      tbVal[3] = 1'b1;
      settle(2);
      checkOutput("clr_mon3",   64'(bus.mon_val[3]), 64'(1));
      checkOutput("clr_before", 64'(bus.edge_cnt),   64'(5));
      bus.cnt_clear = 1'b1;
      @(negedge clock);
      bus.cnt_clear = 1'b0;
      checkOutput("clr_edge",  64'(bus.edge_cnt), 64'(0));
      @(negedge clock);
      checkOutput("clr_after", 64'(bus.edge_cnt), 64'(0));
      tbVal[3] = 1'b0;
      settle(3);

      // Select change onto an already-high pad neither clears nor counts
      pulseBits(38'h8, 2);
      settle(3);
      checkOutput("sel_before", 64'(bus.edge_cnt), 64'(2));
      tbVal[4] = 1'b1;
      settle(3);
      bus.cnt_sel = 6'd4;
      settle(3);
      checkOutput("sel_change", 64'(bus.edge_cnt), 64'(2));

      // Out-of-range select never counts
      bus.cnt_sel = 6'd38;
      pulseBits('1, 2);
      settle(3);
      checkOutput("sel_range", 64'(bus.edge_cnt), 64'(2));

      // Saturation on the narrow counter
      settle(3);
      pulseSat(2);
      settle(3);
      checkOutput("sat_2", 64'(bus2.edge_cnt), 64'(2));
      pulseSat(3);
      settle(3);
      checkOutput("sat_max", 64'(bus2.edge_cnt), 64'(3));

      // Async reset during a wait with the agent driving every pad
      bus.cnt_sel = 6'd3;
      pulseBits(38'h8, 2);
      settle(3);
      checkOutput("pre_rst_cnt", 64'(bus.edge_cnt), 64'(4));
      tbEn = '0;
      drvWrite('1, '1);
      settle(3);
      checkOutput("pre_rst_mon", 64'(bus.mon_val), 64'(38'h3F_FFFF_FFFF));
      @(negedge clock);
      bus.wait_start   = 1'b1;
      bus.wait_mask    = '1;
      bus.wait_value   = '0;
      bus.wait_timeout = 16'd50;
      @(negedge clock);
      bus.wait_start = 1'b0;
      settle(2);
      checkOutput("pre_rst_busy", 64'(bus.wait_busy), 64'(1));
      #2;
      resetb = 1'b0;
      #2;
      checkOutput("rst_pads_released", 64'(countHigh(pad)), 64'(0));
      checkOutput("rst_busy_async",    64'(bus.wait_busy),  64'(0));
      checkOutput("rst_done_async",    64'(bus.wait_done),  64'(0));
      checkOutput("rst_cnt_async",     64'(bus.edge_cnt),   64'(0));
      checkOutput("rst_mon_async",     64'(bus.mon_val),    64'(0));
      @(negedge clock);
      resetb = 1'b1;
      settle(60);
      checkOutput("post_rst_busy",  64'(bus.wait_busy),  64'(0));
      checkOutput("post_rst_pads",  64'(countHigh(pad)), 64'(0));
      checkOutput("queue_empty",    64'(expQ.size()),    64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gpio_pad_agent.md
GPIO_PAD_AGENT -- requirements
Module: gpio_pad_agent

Interface
REQ-001 Parameter NPADS, default 38, number of bidirectional pads handled.
REQ-002 Parameter TMO_W, default 16, width of the wait-timeout counter.
REQ-003 Parameter CNT_W, default 16, width of the edge counter.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 resetb  input  1  reset, asynchronous, active-low.
REQ-006 pad  inout  NPADS  pad bus; each bit is driven or released to high-Z.
REQ-007 drv_wr  input  1  when high, load drv_val and drv_en into the drive registers.
REQ-008 drv_val  input  NPADS  per-pad drive value.
REQ-009 drv_en  input  NPADS  per-pad drive enable.
REQ-010 mon_val  output  NPADS  synchronised pad sample.
REQ-011 wait_start  input  1  starts a masked compare-and-wait.
REQ-012 wait_mask  input  NPADS  compare mask; 1 means compare this pad.
REQ-013 wait_value  input  NPADS  expected pad values.
REQ-014 wait_timeout  input  TMO_W  maximum number of extra compare cycles.
REQ-015 wait_busy  output  1  high while a wait is in progress.
REQ-016 wait_done  output  1  one-cycle pulse when a wait ends.
REQ-017 wait_hit  output  1  result of the last wait: 1 = matched, 0 = timed out.
REQ-018 cnt_sel  input  $clog2(NPADS)  selects the pad whose rising edges are counted.
REQ-019 cnt_clear  input  1  synchronous clear of edge_cnt.
REQ-020 edge_cnt  output  CNT_W  number of rising edges seen on the selected pad.

Function
REQ-021 Pad drive: pad[i] SHALL equal drv_val_q[i] when drv_en_q[i]=1, and 'z' otherwise.
REQ-022 drv_wr=1 SHALL load drv_val_q and drv_en_q together at the clock edge; the pad changes in the cycle after that edge.
REQ-023 mon_val SHALL be a two-flop synchronised copy of pad, giving 2-cycle latency; 'x' and 'z' values pass through unchanged.
REQ-024 Wait FSM states: IDLE, WAIT, DONE.
REQ-025 IDLE->WAIT on wait_start=1; mask, value and timeout SHALL be latched, and the cycle counter cleared to 0.
REQ-026 Each WAIT cycle SHALL evaluate, in priority order:
- match when ((mon_val ^ value_q) & mask_q) == 0 with no x/z on any masked bit -> DONE with hit=1;
- otherwise, if counter == timeout_q -> DONE with hit=0;
- otherwise the counter increments.
REQ-027 An x or z on any masked bit SHALL count as a mismatch.
REQ-028 DONE SHALL assert wait_done for exactly one cycle, then return to IDLE.
REQ-029 wait_busy SHALL be high in WAIT and DONE only.
REQ-030 wait_hit SHALL update on entry to DONE and hold until the next DONE.
REQ-031 wait_start SHALL be ignored while wait_busy=1.
REQ-032 Mask all-zero SHALL produce hit=1 on the first WAIT cycle.
REQ-033 wait_timeout=0 SHALL give exactly one compare cycle.
REQ-034 Worst-case wait length SHALL be timeout_q+1 WAIT cycles.
REQ-035 Edge counter: a per-bit previous-sample register prev_q SHALL track mon_val every cycle.
REQ-036 edge_cnt SHALL increment when mon_val[cnt_sel]=1 and prev_q[cnt_sel]=0.
REQ-037 edge_cnt SHALL saturate at all-ones; it never wraps.
REQ-038 cnt_clear SHALL take priority over increment, and edge_cnt reads 0 in the next cycle.
REQ-039 Changing cnt_sel SHALL NOT clear edge_cnt or create a false edge.
REQ-040 cnt_sel >= NPADS SHALL never increment the counter.

Reset
REQ-041 resetb=0 SHALL asynchronously clear the following, releasing all pads to high-Z: drv_val_q, drv_en_q, both synchroniser stages, prev_q, edge_cnt, FSM=IDLE, counter, wait_hit, wait_done, wait_busy.
REQ-042 Reset during WAIT SHALL abort the wait with no wait_done pulse.
REQ-043 Outputs SHALL be valid from the first clock edge after resetb deasserts.

Verification
REQ-044 Reset, then drv_wr with drv_en=bit5, drv_val=bit5 -> pad[5]=1 one cycle later, all other pads z, mon_val[5]=1 two cycles after that.
REQ-045 wait_start with mask=0x3, value=0x2, timeout=10; external drive pad[1:0]=2'b10 at cycle 4 -> wait_done pulse with hit=1, busy low next cycle.
REQ-046 wait_start with timeout=3 and pads never matching -> exactly 4 WAIT cycles, then wait_done with hit=0; a second wait_start issued mid-wait is ignored.
REQ-047 Masked pad floating (z) with value=0 -> timeout, hit=0; mask=0 -> hit=1 in the first WAIT cycle.
REQ-048 cnt_sel=3 with 5 pulses on pad[3] -> edge_cnt=5; cnt_clear coinciding with an edge -> 0; CNT_W=2 with 5 edges -> saturates at 3.
REQ-049 resetb pulsed low mid-WAIT while pads are driven -> all pads z immediately, no wait_done, edge_cnt=0.
